// File: rtl/logicnets_pipe_ctrl.sv
// rtl/logicnets_pipe_ctrl.sv - stage enable / valid sequencing for a LogicNets layer pipeline
// Carries no data: drives the wrapper's register load enables, stream handshakes, drain FSM and frame counters.
module logicnets_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  input  logic                  drain_req,
  input  logic                  flush,
  output logic                  drain_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      in_count,
  output logic [CNT_W-1:0]      out_count
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] acc;
  logic                  acc_down;

  // Ready ripples from out_ready back to stage 0; a scalar carry keeps the chain acyclic.
  always_comb begin
    adv      = '0;
    acc      = '0;
    acc_down = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      adv[i]   = v[i] & acc_down;
      acc_down = ~v[i] | adv[i];
      acc[i]   = acc_down;
    end
  end

  assign in_ready = acc[0] & (state == ST_RUN) & ~drain_req & ~flush;

  always_comb begin
    stage_en = '0;
    if (!flush) begin
      stage_en[0] = in_valid & in_ready;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_en[i] = v[i-1] & acc[i];
      end
    end
  end

  assign out_valid   = v[NUM_STAGES-1] & ~flush;
  assign stage_valid = v;
  assign busy        = |v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= stage_en | (v & ~adv);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_count  <= '0;
      out_count <= '0;
    end else begin
      in_count  <= in_count + CNT_W'(stage_en[0]);
      out_count <= out_count + CNT_W'(out_valid & out_ready);
    end
  end

  // Emptiness is judged on the registered valids, so a frame leaving this cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      drain_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (drain_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain_req) begin
            state <= ST_RUN;
          end else if (flush || (v == '0)) begin
            state      <= ST_DONE;
            drain_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state      <= ST_RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logicnets_pipe_ctrl.sv
// tb/tb_logicnets_pipe_ctrl.sv - bench for logicnets_pipe_ctrl with a slot-occupancy model
// Frames are tracked as ids in pipeline slots; outputs are derived from slot movement each cycle.
module tb_logicnets_pipe_ctrl;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready, drain_req, flush;
  logic          in_ready, out_valid, drain_done, busy;
  logic [NS-1:0] stage_en, stage_valid;
  logic [31:0]   in_count, out_count;

  logic_wrap_unused_guard_dummy_never u_unused ();

  logicnets_pipe_ctrl #(.NUM_STAGES(NS), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .stage_en(stage_en),
    .stage_valid(stage_valid), .drain_req(drain_req), .flush(flush),
    .drain_done(drain_done), .busy(busy), .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: slot[i] holds a frame id or -1 when empty.
  int            slot[NS];
  int            m_nxt[NS];
  int            mstate = 0;
  int            next_id = 0;
  logic [31:0]   m_in = '0;
  logic [31:0]   m_out = '0;
  logic [NS-1:0] m_en;
  logic          m_ir, m_ov;

  initial for (int i = 0; i < NS; i++) slot[i] = -1;

  function automatic void model_eval();
    m_en = '0;
    m_ir = 1'b0;
    m_ov = (slot[NS-1] >= 0) && !flush;
    for (int i = 0; i < NS; i++) m_nxt[i] = flush ? -1 : slot[i];
    if (!flush) begin
      for (int i = NS - 1; i >= 0; i--) begin
        if (slot[i] >= 0) begin
          if (i == NS - 1) begin
            if (out_ready) m_nxt[i] = -1;
          end else if (m_nxt[i+1] < 0) begin
            m_nxt[i+1] = slot[i];
            m_nxt[i]   = -1;
            m_en[i+1]  = 1'b1;
          end
        end
      end
      m_ir = (m_nxt[0] < 0) && (mstate == 0) && !drain_req;
      if (m_ir && in_valid) begin
        m_nxt[0] = next_id;
        m_en[0]  = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) slot[i] = -1;
      mstate = 0; m_in = '0; m_out = '0; next_id = 0;
    end else begin
      bit empty;
      model_eval();
      empty = 1'b1;
      for (int i = 0; i < NS; i++) if (slot[i] >= 0) empty = 1'b0;
      if (m_ov && out_ready) m_out = m_out + 1;
      if (m_en[0]) begin m_in = m_in + 1; next_id++; end
      case (mstate)
        0: if (drain_req) mstate = 1;
        1: if (!drain_req) mstate = 0; else if (flush || empty) mstate = 2;
        2: if (!drain_req) mstate = 0;
        default: mstate = 0;
      endcase
      for (int i = 0; i < NS; i++) slot[i] = m_nxt[i];
    end
  end

  always @(negedge clk) begin
    logic [NS-1:0] exp_sv;
    model_eval();
    for (int i = 0; i < NS; i++) exp_sv[i] = (slot[i] >= 0);
    chk("stage_en",    32'(stage_en),    32'(m_en));
    chk("stage_valid", 32'(stage_valid), 32'(exp_sv));
    chk("in_ready",    32'(in_ready),    32'(m_ir));
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("busy",        32'(busy),        32'(|exp_sv));
    chk("drain_done",  32'(drain_done),  32'(mstate == 2));
    chk("in_count",    in_count,         m_in);
    chk("out_count",   out_count,        m_out);
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; drain_req = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    chk("rst_stage_valid", 32'(stage_valid), 32'h0);
    chk("rst_in_ready",    32'(in_ready),    32'h1);
    chk("rst_drain_done",  32'(drain_done),  32'h0);
    chk("rst_in_count",    in_count,         32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int first, nov, drop, acc_n, ir_bad, bz, dd;

    // Reset mid-stream, asserted between clock edges
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_in_count", in_count, 32'd3);
    #2 rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("async_stage_valid", 32'(stage_valid), 32'h0);
    chk("async_out_valid",   32'(out_valid),   32'h0);
    chk("async_in_count",    in_count,         32'h0);
    #3 rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Streaming
    do_reset();
    first = -1; nov = 0; drop = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 10); out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && first < 0) first = c;
      if (out_valid) nov++;
      if (!in_ready) drop = 1;
      @(posedge clk); #1;
    end
    chk("stream_latency", 32'(first), 32'd4);
    chk("stream_nout",    32'(nov),   32'd10);
    chk("stream_drop",    32'(drop),  32'd0);
    chk("stream_in_cnt",  in_count,   32'd10);
    chk("stream_out_cnt", out_count,  32'd10);

    // Backpressure
    do_reset();
    acc_n = 0; ir_bad = 0;
    for (int c = 0; c < 25; c++) begin
      in_valid = (acc_n < 6); out_ready = !(c >= 4 && c <= 9);
      @(negedge clk);
      if (c == 4) chk("bp_full", 32'(stage_valid), 32'hF);
      if (c >= 4 && c <= 9 && in_ready) ir_bad++;
      if (c == 10) chk("bp_ready_back", 32'(in_ready), 32'h1);
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
    end
    chk("bp_ir_low",   32'(ir_bad), 32'd0);
    chk("bp_in_cnt",   in_count,    32'd6);
    chk("bp_out_cnt",  out_count,   32'd6);

    // Bubble collapse
    do_reset();
    for (int c = 0; c < 14; c++) begin
      in_valid = (c == 0 || c == 3); out_ready = (c >= 8);
      @(negedge clk);
      if (c == 7)  chk("bub_adjacent", 32'(stage_valid), 32'hC);
      if (c == 8)  chk("bub_pop0", 32'(out_valid), 32'h1);
      if (c == 9)  chk("bub_pop1", 32'(out_valid), 32'h1);
      if (c == 10) chk("bub_pop2", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
    end
    chk("bub_out_cnt", out_count, 32'd2);

    // Drain
    do_reset();
    bz = -1; dd = -1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 3); out_ready = 1'b1; drain_req = (c >= 3 && c < 10);
      @(negedge clk);
      if (c == 3) chk("drain_block", 32'(in_ready), 32'h0);
      if (c > 3 && !busy && bz < 0) bz = c;
      if (drain_done && dd < 0) dd = c;
      if (c == 10) chk("drain_still_done", 32'(in_ready), 32'h0);
      if (c == 11) chk("drain_resume", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
    end
    chk("drain_idle_cyc", 32'(bz),  32'd7);
    chk("drain_done_cyc", 32'(dd),  32'd8);
    chk("drain_out_cnt",  out_count, 32'd3);

    // Flush with simultaneous accept
    do_reset();
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3); out_ready = 1'b1; flush = (c == 2);
      @(negedge clk);
      if (c == 2) begin
        chk("fl_in_ready", 32'(in_ready), 32'h0);
        chk("fl_stage_en", 32'(stage_en), 32'h0);
      end
      if (c == 3) begin
        chk("fl_stage_valid", 32'(stage_valid), 32'h0);
        chk("fl_busy",        32'(busy),        32'h0);
        chk("fl_in_cnt",      in_count,         32'd2);
        chk("fl_out_cnt",     out_count,        32'd0);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

module logic_wrap_unused_guard_dummy_never;
endmodule

// File: doc/logicnets_pipe_ctrl.md
Name: logicnets_pipe_ctrl

Overview:
Sequencing controller for a chain of combinational LogicNets layers separated by pipeline registers. It generates per-stage load enables for the layer data registers and tracks per-stage valid bits. It exposes a valid/ready stream interface at the network input and output, with bubble-collapsing backpressure. It also provides a drain/flush state machine and frame counters for the top-level accelerator wrapper. Data registers live in the wrapper; this block carries no data.

Parameters:
NUM_STAGES, 4, number of pipeline register stages (one per layer boundary); legal range 1..16
CNT_W, 32, width of the accepted/emitted frame counters

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream frame available
in_ready  output  1  controller can accept a frame this cycle
out_valid  output  1  last stage holds a valid result
out_ready  input  1  downstream consumes result this cycle
stage_en  output  NUM_STAGES  load enable for data register of stage i (bit 0 = input register)
stage_valid  output  NUM_STAGES  valid bit of each stage register
drain_req  input  1  stop accepting input and empty the pipeline
flush  input  1  synchronous discard of all in-flight frames
drain_done  output  1  pipeline is empty following a drain request
busy  output  1  any stage_valid bit set
in_count  output  CNT_W  frames accepted since reset
out_count  output  CNT_W  frames emitted since reset

Behaviour:
- Reset (async, rst=1): all stage_valid=0; in_count=out_count=0; FSM=RUN; drain_done=0; busy=0. Combinational outputs follow from these values: out_valid=0, stage_en=0, and in_ready=1 unless drain_req is high.
- Per stage i: adv[i] = v[i] & acc[i+1], with acc[NUM_STAGES] = out_ready. acc[i] = ~v[i] | adv[i].
- Enables: stage_en[0] = in_valid & in_ready & acc[0]. For i>0, stage_en[i] = v[i-1] & acc[i].
- Valid update: v[i] <= stage_en[i] ? 1 : (adv[i] ? 0 : v[i]).
- in_ready = acc[0] & (FSM==RUN) & ~drain_req.
- out_valid = v[NUM_STAGES-1].
- The ready chain is combinational from out_ready to in_ready (no skid buffer).
- Latency: a frame accepted at cycle t (in_valid & in_ready) gives out_valid at t+NUM_STAGES if unstalled. Throughput is 1 frame/cycle.
- Stall: frames hold while out_ready=0. Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- FSM states and transitions:
  - RUN -> DRAIN on drain_req=1.
  - DRAIN: inputs blocked. Goes to DONE when all v=0. Evaluated on the registered v, so a frame leaving this cycle is counted as still present.
  - DONE: drain_done=1. Goes to RUN when drain_req=0.
  - If drain_req drops while in DRAIN, return to RUN next cycle.
- flush=1 (any state): all v <= 0 next cycle; stage_en forced 0; in_ready=0; out_valid forced 0 that cycle; counters not incremented. The FSM is unchanged, except DRAIN -> DONE next cycle.
- Counters:
  - in_count increments on stage_en[0]; out_count on out_valid & out_ready.
  - Both wrap modulo 2^CNT_W.
  - Simultaneous accept and emit increment both.
- busy = |v (registered). drain_done is registered and equals (FSM==DONE).

Test Plan:
- Reset mid-stream: in_valid=1 and out_ready=1 for 3 cycles, then rst pulse asynchronous to the clock edge -> v=0, counters=0, out_valid=0 immediately; in_ready=1 after rst falls.
- Streaming, NUM_STAGES=4: in_valid=1 and out_ready=1 for 10 cycles from t=0 -> out_valid first at t=4 and stays high for 10 cycles; in_count=out_count=10; in_ready never drops.
- Backpressure: 6 frames presented, out_ready=0 from cycle 4 to 9 -> stage_valid=4'b1111 by cycle 4 and in_ready=0 until cycle 10; when out_ready returns, out_count reaches 6 with no loss or duplication (scoreboard on frame order).
- Bubble collapse: one frame, then a 2-cycle in_valid gap, then one frame; out_ready=0 until both are inside -> both occupy stages 3 and 2 adjacently; out_valid then pops 2 frames in back-to-back cycles.
- Drain: 3 frames in flight, drain_req=1 -> in_ready=0 at once; drain_done=1 one cycle after busy=0; out_count=3; drain_req=0 -> RUN and in_ready=1 next cycle.
- Flush with simultaneous accept: flush=1 while in_valid=1 and 2 frames in flight -> stage_valid=0 next cycle, in_count not incremented, out_count unchanged, busy=0.
